// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared declarations for the memory-stage responder: access-size and
//   extension encodings (as produced by the instruction decoder), the FSM
//   state encoding and the alignment rule used by the lane steering logic.
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    // mem_mode encodings
    localparam logic [1:0] MEM_op_none  = 2'b00;
    localparam logic [1:0] MEM_op_word  = 2'b01;
    localparam logic [1:0] MEM_op_half  = 2'b10;
    localparam logic [1:0] MEM_op_byte  = 2'b11;

    // mem_ext encodings; any value other than sign behaves as zero-extend
    localparam logic [1:0] MEM_ext_sign = 2'b11;
    localparam logic [1:0] MEM_ext_zero = 2'b00;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } dmem_state_e;

    // True when an access of the given size at byte offset off sits inside
    // one naturally aligned container. Bytes are always aligned.
    function automatic logic is_aligned(input logic [1:0] mode, input logic [1:0] off);
        logic ok;
        case (mode)
            MEM_op_word: ok = (off == 2'b00);
            MEM_op_half: ok = (off[0] == 1'b0);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Word-wide data bus between the memory-stage responder (master) and the
//   data memory / bus fabric (slave).
//
//   Handshake: the master raises bus_req together with stable bus_we,
//   bus_addr, bus_be and bus_wdata, and holds all of them unchanged until the
//   slave answers with a single-cycle bus_ack pulse (bus_rdata is valid only
//   while bus_ack=1). The master drops bus_req in the cycle after the ack, or
//   after its own timeout, and never issues a new request in that cycle.
//
//   Signals:
//     bus_req    master->slave  transaction valid
//     bus_we     master->slave  1 = write
//     bus_addr   master->slave  word address (byte address [31:2])
//     bus_be     master->slave  byte enables, bit i = byte lane i
//     bus_wdata  master->slave  lane-steered store data
//     bus_ack    slave->master  transaction complete, one-cycle pulse
//     bus_rdata  slave->master  read word, valid with bus_ack
// ---------------------------------------------------------------------------
interface dmem_responder_if;

    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/dmem_lane_steer.sv
// ---------------------------------------------------------------------------
// dmem_lane_steer
//   Purely combinational byte-lane logic (little-endian, lane i = bits
//   [8i+7:8i]):
//     - alignment check for the access size,
//     - byte enables for the addressed lanes,
//     - store data replicated so the addressed lanes carry it,
//     - load data extracted to bit 0 and sign/zero extended.
//
//   Ports:
//     mode        in   access size (word/half/byte/none)
//     ext         in   extension select (sign when MEM_ext_sign)
//     off         in   byte offset inside the word (addr[1:0])
//     store_data  in   unsteered store data
//     load_word   in   raw read word from the bus
//     aligned     out  access fits its natural container
//     be          out  byte enables
//     store_lanes out  replicated store data
//     load_data   out  extended load result
// ---------------------------------------------------------------------------
module dmem_lane_steer
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [1:0]  ext,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic        aligned,
    output logic [3:0]  be,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic        sign_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        aligned     = is_aligned(mode, off);
        be          = 4'b0000;
        store_lanes = store_data;
        load_data   = load_word;

        case (ext)
            MEM_ext_sign: sign_ext = 1'b1;
            MEM_ext_zero: sign_ext = 1'b0;
            default:      sign_ext = 1'b0;
        endcase

        byte_sel = load_word[{off, 3'b000} +: 8];
        half_sel = off[1] ? load_word[31:16] : load_word[15:0];

        case (mode)
            MEM_op_byte: begin
                be          = 4'b0001 << off;
                store_lanes = {4{store_data[7:0]}};
                load_data   = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            end
            MEM_op_half: begin
                be          = off[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = {{16{sign_ext & half_sel[15]}}, half_sel};
            end
            MEM_op_word: begin
                be          = 4'b1111;
            end
            default: begin
                be          = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Memory-stage responder. Turns load/store requests from the EX/MM
//   register into byte-enabled word transactions on a multi-cycle bus,
//   stalls the pipeline until the bus acknowledges (or times out) and
//   returns the extended load result.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     mem_read     load request
//     mem_write    store request (wins over mem_read)
//     mem_mode     access size: 01 word, 10 half, 11 byte, 00 none
//     mem_ext      11 sign-extend, otherwise zero-extend
//     addr, wdata  byte address and unsteered store data
//     rdata        extended load result, valid when stall drops after a load
//     stall        freezes the upstream pipeline
//     misalign     one-cycle pulse on an unaligned access
//     bus_err      one-cycle pulse (in the DONE cycle) on bus timeout
//     bus          master side of dmem_responder_if
//     dbg_state    current FSM state
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_mode,
    input  logic [1:0]        mem_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    dmem_responder_if.master  bus,
    output dmem_state_e       dbg_state
);

    dmem_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             bus_err_q, bus_err_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [29:0]      baddr_q, baddr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      bwdata_q, bwdata_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       ext_q, ext_d;
    logic [1:0]       off_q, off_d;

    logic             acc;
    logic             timeout_hit;
    logic [1:0]       sel_mode;
    logic [1:0]       sel_off;
    logic             aligned;
    logic [3:0]       steer_be;
    logic [31:0]      steer_wdata;
    logic [31:0]      steer_rdata;

    assign acc         = (mem_read | mem_write) && (mem_mode != MEM_op_none);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // In IDLE the steering works on the live request; while the transaction
    // is outstanding it works on the captured size/offset so the load
    // extraction matches the request that was issued.
    assign sel_mode = (state_q == ST_IDLE) ? mem_mode  : mode_q;
    assign sel_off  = (state_q == ST_IDLE) ? addr[1:0] : off_q;

    dmem_lane_steer u_lane_steer (
        .mode        (sel_mode),
        .ext         (ext_q),
        .off         (sel_off),
        .store_data  (wdata),
        .load_word   (bus.bus_rdata),
        .aligned     (aligned),
        .be          (steer_be),
        .store_lanes (steer_wdata),
        .load_data   (steer_rdata)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (acc && aligned)                state_d = ST_WAIT;
            ST_WAIT: if (bus.bus_ack || timeout_hit)    state_d = ST_DONE;
            // The request still on the inputs during DONE belongs to the
            // instruction just served, so DONE never looks at it.
            ST_DONE:                                    state_d = ST_IDLE;
            default:                                    state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        stall     = 1'b0;
        misalign  = 1'b0;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        req_d     = req_q;
        we_d      = we_q;
        baddr_d   = baddr_q;
        be_d      = be_q;
        bwdata_d  = bwdata_q;
        mode_d    = mode_q;
        ext_d     = ext_q;
        off_d     = off_q;

        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (aligned) begin
                        stall    = 1'b1;
                        cnt_d    = '0;
                        req_d    = 1'b1;
                        we_d     = mem_write;
                        baddr_d  = addr[31:2];
                        be_d     = steer_be;
                        bwdata_d = steer_wdata;
                        mode_d   = mem_mode;
                        ext_d    = mem_ext;
                        off_d    = addr[1:0];
                    end else begin
                        misalign = 1'b1;
                        rdata_d  = '0;
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                // An ack arriving on the last count still completes normally.
                if (bus.bus_ack) begin
                    req_d = 1'b0;
                    if (!we_q) rdata_d = steer_rdata;
                end else if (timeout_hit) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            default: begin
            end
        endcase

        // Reset releases the pipeline immediately, even with a request held
        // on the inputs.
        if (!rst_n) begin
            stall    = 1'b0;
            misalign = 1'b0;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            be_q      <= '0;
            bwdata_q  <= '0;
            mode_q    <= MEM_op_none;
            ext_q     <= MEM_ext_zero;
            off_q     <= 2'b00;
        end else begin
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            req_q     <= req_d;
            we_q      <= we_d;
            baddr_q   <= baddr_d;
            be_q      <= be_d;
            bwdata_q  <= bwdata_d;
            mode_q    <= mode_d;
            ext_q     <= ext_d;
            off_q     <= off_d;
        end
    end

    assign rdata         = rdata_q;
    assign bus_err       = bus_err_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = baddr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = bwdata_q;
    assign dbg_state     = state_q;

endmodule
